lcd_text_writer: RTL and testbench

Sequences a 32-character, two-line text frame onto the HD44780-style LCD once the 4-bit init sequence has completed. Issues a set-DDRAM-address command per line, then each character as RS=1 high/low nibble transfers to `lcd_transfer`, one transfer at a time under its send/done handshake. Sits beside `lcd_init_comb`. The top level routes `lcd_transfer` inputs to this block once `initDone` is high.

---
 rtl/lcd_pkg.sv | 39 +++
 rtl/lcd_text_writer.sv | 149 ++++++++++++++
 tb/tb_lcd_text_writer.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Shared LCD definitions: text writer states, RS bit, delay helpers and
// DDRAM line base addresses.
package lcd_pkg;

  typedef enum logic [2:0] {
    TS_IDLE    = 3'd0,
    TS_ADDR_HI = 3'd1,
    TS_ADDR_LO = 3'd2,
    TS_CHAR_HI = 3'd3,
    TS_CHAR_LO = 3'd4,
    TS_DONE    = 3'd5
  } text_state_t;

  // RS=1 selects the data register; OR it onto a nibble to send a character.
  localparam logic [4:0] RS_DATA = 5'b10000;

  // DDRAM "set address" commands for the start of each display line.
  localparam logic [7:0] LINE0_ADDR = 8'h80;
  localparam logic [7:0] LINE1_ADDR = 8'hC0;

  // Post-transfer delays in clock cycles, truncating integer arithmetic.
  function automatic logic [20:0] t1us(input int freq);
    return 21'(freq / 1000000);
  endfunction

  function automatic logic [20:0] t10us(input int freq);
    return 21'(10 * (freq / 1000000));
  endfunction

  function automatic logic [20:0] t53us(input int freq);
    return 21'(53 * (freq / 1000000));
  endfunction

  // Control codes and DEL would show as garbage glyphs; print a space instead.
  function automatic logic [7:0] lcd_sanitise(input logic [7:0] c);
    return ((c < 8'h20) || (c == 8'h7F)) ? 8'h20 : c;
  endfunction

endpackage

// File: rtl/lcd_text_writer.sv
// Streams a two-line text frame to the LCD as nibble transfers through
// lcd_transfer: a set-DDRAM-address command per line, then each character.
//
// Handshake: xfer_send/xfer_cmd/xfer_delay form a request that stays stable
// while xfer_send=1; the edge that samples xfer_done=1 with xfer_send=1
// completes it, xfer_send drops for one cycle and the next request appears
// on the following edge. xfer_done seen while xfer_send=0 is ignored.
module lcd_text_writer
  import lcd_pkg::*;
#(
  parameter int FREQ           = 50000000,
  parameter int CHARS_PER_LINE = 16,
  parameter int LINES          = 2
) (
  input  logic                                CLK,
  input  logic                                RESET,
  input  logic                                init_done,
  input  logic                                write_text,
  input  logic [8*LINES*CHARS_PER_LINE-1:0]   text,
  output logic                                ready,
  output logic                                busy,
  output logic                                text_done,
  output logic                                xfer_send,
  output logic [4:0]                          xfer_cmd,
  output logic [20:0]                         xfer_delay,
  input  logic                                xfer_done,
  output logic [2:0]                          state_dbg
);

  localparam int FRAME_BITS = 8 * LINES * CHARS_PER_LINE;
  localparam logic [20:0] T10US = t10us(FREQ);
  localparam logic [20:0] T53US = t53us(FREQ);

  text_state_t           state;
  logic [FRAME_BITS-1:0] textReg;
  logic [3:0]            charCnt;
  logic                  line;

  logic [7:0]  curChar;
  logic [7:0]  lineAddr;
  logic [4:0]  nextCmd;
  logic [20:0] nextDelay;
  logic        lastChar;
  logic        lastLine;

  assign ready     = init_done & ~busy;
  assign state_dbg = state;

  // The latched frame shifts left per character, so the current one is at the MSBs.
  assign curChar  = lcd_sanitise(textReg[FRAME_BITS-1 -: 8]);
  assign lineAddr = line ? LINE1_ADDR : LINE0_ADDR;
  assign lastChar = (charCnt == 4'(CHARS_PER_LINE - 1));
  assign lastLine = (line == 1'(LINES - 1));

  // Command and delay the current state would present on its next request.
  always_comb begin
    nextCmd   = 5'd0;
    nextDelay = 21'd0;
    case (state)
      TS_ADDR_HI: begin
        nextCmd   = {1'b0, lineAddr[7:4]};
        nextDelay = T10US;
      end
      TS_ADDR_LO: begin
        nextCmd   = {1'b0, lineAddr[3:0]};
        nextDelay = T53US;
      end
      TS_CHAR_HI: begin
        nextCmd   = RS_DATA | {1'b0, curChar[7:4]};
        nextDelay = T10US;
      end
      TS_CHAR_LO: begin
        nextCmd   = RS_DATA | {1'b0, curChar[3:0]};
        nextDelay = T53US;
      end
      default: begin
        nextCmd   = 5'd0;
        nextDelay = 21'd0;
      end
    endcase
  end

  // Frame sequencer: one request at a time, advancing on each completed transfer.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= TS_IDLE;
      textReg    <= '0;
      charCnt    <= 4'd0;
      line       <= 1'b0;
      busy       <= 1'b0;
      text_done  <= 1'b0;
      xfer_send  <= 1'b0;
      xfer_cmd   <= 5'd0;
      xfer_delay <= 21'd0;
    end else begin
      text_done <= 1'b0;
      case (state)
        TS_IDLE: begin
          if (write_text && ready) begin
            textReg <= text;
            charCnt <= 4'd0;
            line    <= 1'b0;
            busy    <= 1'b1;
            state   <= TS_ADDR_HI;
          end
        end

        TS_ADDR_HI, TS_ADDR_LO, TS_CHAR_HI, TS_CHAR_LO: begin
          if (!xfer_send) begin
            xfer_send  <= 1'b1;
            xfer_cmd   <= nextCmd;
            xfer_delay <= nextDelay;
          end else if (xfer_done) begin
            xfer_send <= 1'b0;
            case (state)
              TS_ADDR_HI: state <= TS_ADDR_LO;
              TS_ADDR_LO: state <= TS_CHAR_HI;
              TS_CHAR_HI: state <= TS_CHAR_LO;
              default: begin
                textReg <= textReg << 8;
                if (lastChar) begin
                  charCnt <= 4'd0;
                  if (lastLine) begin
                    text_done <= 1'b1;
                    state     <= TS_DONE;
                  end else begin
                    line  <= line + 1'b1;
                    state <= TS_ADDR_HI;
                  end
                end else begin
                  charCnt <= charCnt + 4'd1;
                  state   <= TS_CHAR_HI;
                end
              end
            endcase
          end
        end

        TS_DONE: begin
          busy  <= 1'b0;
          state <= TS_IDLE;
        end

        default: state <= TS_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_text_writer.sv
// Self-checking bench for lcd_text_writer: a behavioural lcd_transfer
// responder, a frame-level model of the expected transfer list, and checks
// on reset, handshake timing, sanitising, busy rejection and mid-frame reset.
module tb_lcd_text_writer;

  localparam int FREQ  = 50000000;
  localparam int CPL   = 16;
  localparam int LINES = 2;
  localparam int NXFER = LINES * (2 + 2 * CPL);
  localparam int T10   = 10 * (FREQ / 1000000);
  localparam int T53   = 53 * (FREQ / 1000000);

  logic         CLK = 1'b0;
  logic         RESET;
  logic         init_done;
  logic         write_text;
  logic [255:0] text;
  logic         ready;
  logic         busy;
  logic         text_done;
  logic         xfer_send;
  logic [4:0]   xfer_cmd;
  logic [20:0]  xfer_delay;
  logic         xfer_done;
  logic [2:0]   state_dbg;

  int tests_run    = 0;
  int tests_failed = 0;
  int send_rises   = 0;
  int done_pulses  = 0;
  logic prev_send  = 1'b0;

  // {cmd[4:0], delay[20:0]} for each transfer of the frame, in order
  logic [25:0] exp_q[$];

  lcd_text_writer #(.FREQ(FREQ), .CHARS_PER_LINE(CPL), .LINES(LINES)) dut (
    .CLK(CLK), .RESET(RESET), .init_done(init_done), .write_text(write_text),
    .text(text), .ready(ready), .busy(busy), .text_done(text_done),
    .xfer_send(xfer_send), .xfer_cmd(xfer_cmd), .xfer_delay(xfer_delay),
    .xfer_done(xfer_done), .state_dbg(state_dbg)
  );

  // clock
  always #5 CLK = ~CLK;

  // count request starts and frame-done pulses
  always @(negedge CLK) begin
    if (xfer_send && !prev_send) send_rises++;
    if (text_done) done_pulses++;
    prev_send = xfer_send;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model_char(input logic [7:0] c);
    if (c < 8'h20 || c == 8'h7F) return 8'h20;
    return c;
  endfunction

  function automatic logic [7:0] frame_byte(input logic [255:0] f, input int idx);
    return f[255 - 8*idx -: 8];
  endfunction

  // Frame model: per line an address command pair, then each char as two nibbles.
  task automatic build_expected(input logic [255:0] frame);
    logic [7:0] addr;
    logic [7:0] c;
    exp_q.delete();
    for (int ln = 0; ln < LINES; ln++) begin
      addr = (ln == 0) ? 8'h80 : 8'hC0;
      exp_q.push_back({1'b0, addr[7:4], 21'(T10)});
      exp_q.push_back({1'b0, addr[3:0], 21'(T53)});
      for (int k = 0; k < CPL; k++) begin
        c = model_char(frame_byte(frame, ln*CPL + k));
        exp_q.push_back({1'b1, c[7:4], 21'(T10)});
        exp_q.push_back({1'b1, c[3:0], 21'(T53)});
      end
    end
  endtask

  // Run one frame through a responder that completes each transfer ~5 cycles
  // after the request. glitch_at: pulse write_text while busy and hold
  // xfer_done into the send gap. reset_at: assert RESET during that transfer.
  task automatic run_frame(input logic [255:0] frame, input int glitch_at,
                           input int reset_at, input int initdrop_at);
    logic [25:0] exp;
    logic [4:0]  cmd0;
    logic [20:0] dly0;
    logic [7:0]  raw;
    logic [4:0]  first4 [4];
    int waitc, bad, gap_exp, r, rises0, pulses0;
    first4[0] = 5'h08; first4[1] = 5'h00; first4[2] = 5'h14; first4[3] = 5'h18;
    build_expected(frame);
    rises0  = send_rises;
    pulses0 = done_pulses;
    text = frame;
    @(negedge CLK); write_text = 1'b1;
    @(negedge CLK); write_text = 1'b0;
    text = {8{$urandom()}};
    @(negedge CLK);
    check_eq("start_send", xfer_send, 1);
    check_eq("start_busy", busy, 1);
    gap_exp = 0;
    for (int i = 0; i < NXFER; i++) begin
      waitc = 0;
      while (!xfer_send && waitc < 50) begin
        @(negedge CLK);
        waitc++;
      end
      check_eq($sformatf("send_seen%0d", i), xfer_send, 1);
      if (!xfer_send) return;
      check_eq($sformatf("send_gap%0d", i), waitc, gap_exp);
      exp = exp_q.pop_front();
      check_eq($sformatf("cmd%0d", i), xfer_cmd, exp[25:21]);
      check_eq($sformatf("delay%0d", i), xfer_delay, exp[20:0]);
      if (frame == "HELLO WORLD 1234LCD LINE TWO OK!" && i < 4)
        check_eq($sformatf("first4_%0d", i), xfer_cmd, first4[i]);
      if (i == 34) check_eq("line1_addr_hi", xfer_cmd, 5'h0C);
      r = i % 34;
      if (r >= 2) begin
        raw = frame_byte(frame, (i / 34) * CPL + (r - 2) / 2);
        if (raw < 8'h20 || raw == 8'h7F)
          check_eq($sformatf("ctrl_space%0d", i), xfer_cmd, (r % 2 == 0) ? 5'h12 : 5'h10);
      end
      if (i == reset_at) begin
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        check_eq("rst_send", xfer_send, 0);
        check_eq("rst_cmd", xfer_cmd, 0);
        check_eq("rst_delay", xfer_delay, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_text_done", text_done, 0);
        return;
      end
      if (i == initdrop_at) init_done = 1'b0;
      cmd0 = xfer_cmd;
      dly0 = xfer_delay;
      bad  = 0;
      for (int w = 0; w < 4; w++) begin
        @(negedge CLK);
        write_text = (i == glitch_at && w == 0);
        if (xfer_send !== 1'b1 || xfer_cmd !== cmd0 || xfer_delay !== dly0) bad++;
      end
      write_text = 1'b0;
      check_eq($sformatf("stable%0d", i), bad, 0);
      xfer_done = 1'b1;
      @(negedge CLK);
      check_eq($sformatf("drop%0d", i), xfer_send, 0);
      check_eq($sformatf("text_done_at%0d", i), text_done, (i == NXFER - 1) ? 1 : 0);
      if (i == glitch_at) begin
        // done stays high through the gap; it must not complete the next request
        @(negedge CLK);
        gap_exp = 0;
      end else begin
        gap_exp = 1;
      end
      xfer_done = 1'b0;
    end
    @(negedge CLK);
    check_eq("done_clear", text_done, 0);
    check_eq("busy_clear", busy, 0);
    init_done = 1'b1;
    check_eq("xfer_count", send_rises - rises0, NXFER);
    check_eq("done_pulses", done_pulses - pulses0, 1);
  endtask

  initial begin
    logic [255:0] f;
    int rises0;
    RESET = 1'b1; init_done = 1'b0; write_text = 1'b0; xfer_done = 1'b0; text = '0;
    repeat (3) @(negedge CLK);
    check_eq("reset_send", xfer_send, 0);
    check_eq("reset_cmd", xfer_cmd, 0);
    check_eq("reset_delay", xfer_delay, 0);
    check_eq("reset_busy", busy, 0);
    check_eq("reset_text_done", text_done, 0);
    RESET = 1'b0;

    // start before the LCD is initialised must be ignored
    text = "HELLO WORLD 1234LCD LINE TWO OK!";
    rises0 = send_rises;
    @(negedge CLK); write_text = 1'b1;
    @(negedge CLK); write_text = 1'b0;
    check_eq("noinit_ready", ready, 0);
    repeat (10) @(negedge CLK);
    check_eq("noinit_sends", send_rises - rises0, 0);
    check_eq("noinit_busy", busy, 0);

    init_done = 1'b1;
    @(negedge CLK);
    check_eq("init_ready", ready, 1);

    run_frame("HELLO WORLD 1234LCD LINE TWO OK!", -1, -1, -1);

    // stray xfer_done while idle starts nothing
    rises0 = send_rises;
    @(negedge CLK); xfer_done = 1'b1;
    @(negedge CLK); xfer_done = 1'b0;
    repeat (3) @(negedge CLK);
    check_eq("idle_stray_done", send_rises - rises0, 0);
    check_eq("idle_ready", ready, 1);

    // control characters, busy start strobe, stray done, init_done drop
    for (int k = 0; k < 32; k++) f[255 - 8*k -: 8] = 8'($urandom_range(32, 126));
    f[255 - 8*3 -: 8]  = 8'h0A;
    f[255 - 8*20 -: 8] = 8'h7F;
    run_frame(f, 10, -1, 30);

    // fully random bytes
    for (int k = 0; k < 32; k++) f[255 - 8*k -: 8] = 8'($urandom_range(0, 255));
    run_frame(f, 41, -1, -1);

    // reset during transfer 20, then a fresh frame from the top
    for (int k = 0; k < 32; k++) f[255 - 8*k -: 8] = 8'($urandom_range(0, 255));
    run_frame(f, -1, 19, -1);
    for (int k = 0; k < 32; k++) f[255 - 8*k -: 8] = 8'($urandom_range(0, 255));
    run_frame(f, -1, -1, -1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
